// File: rtl/gate_bist_pkg.sv
// Shared types and truth-table constants for the gate BIST sequencer.
// Bit i of a truth constant is the expected output for input vector i.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  // Two-input gates: vector = {A,B}, B in the LSB
  localparam logic [3:0] TRUTH_NAND2 = 4'b0111;
  localparam logic [3:0] TRUTH_NOR2  = 4'b0001;
  localparam logic [3:0] TRUTH_AND2  = 4'b1000;

endpackage

// File: rtl/gate_bist_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag; parks at zero until reloaded.
// Shared by the gate BIST sequencers to time stimulus settling.
module bist_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks a combinational gate through every input vector,
// lets each settle, compares against a truth constant and reports results.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int                          N_INPUTS      = 2,
  parameter int                          SETTLE_CYCLES = 2,
  parameter logic [(2**N_INPUTS)-1:0]    TRUTH         = TRUTH_NAND2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic [N_INPUTS-1:0]     stim,
  input  logic                    resp,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [(2**N_INPUTS)-1:0] fail_vec,
  output logic [N_INPUTS:0]       err_count
);

  localparam int NV = 2**N_INPUTS;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]       SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST    = '1;

  bist_state_e           r_state;
  bist_state_e           w_next;
  logic [N_INPUTS-1:0]   r_vec;
  logic [NV-1:0]         r_fail_vec;
  logic [N_INPUTS:0]     r_err;
  logic                  r_pass;
  logic                  w_load;
  logic                  w_zero;
  logic                  w_last;
  logic                  w_miss;
  logic                  w_accept;

  assign w_accept = start && !abort;
  assign w_last   = (r_vec == VEC_LAST);
  assign w_miss   = (resp != TRUTH[r_vec]);

  bist_settle_timer #(
    .W (SW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (SETTLE_LOAD),
    .zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = SETTLE;
          w_load = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_zero) begin
          w_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = SETTLE;
          w_load = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Abort discards partial results so a cancelled run never looks valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec      <= '0;
      r_fail_vec <= '0;
      r_err      <= '0;
      r_pass     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_vec      <= '0;
            r_fail_vec <= '0;
            r_err      <= '0;
            r_pass     <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            r_fail_vec <= '0;
            r_err      <= '0;
            r_pass     <= 1'b0;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_fail_vec <= '0;
            r_err      <= '0;
            r_pass     <= 1'b0;
          end else begin
            if (w_miss) begin
              r_fail_vec[r_vec] <= 1'b1;
              r_err             <= r_err + 1'b1;
            end
            if (!w_last) begin
              r_vec <= r_vec + 1'b1;
            end
          end
        end
        DONE: begin
          r_pass <= (r_err == '0);
        end
        default: begin
          r_vec <= '0;
        end
      endcase
    end
  end

  assign busy      = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done      = (r_state == DONE);
  assign stim      = busy ? r_vec : '0;
  assign pass      = r_pass;
  assign fail_vec  = r_fail_vec;
  assign err_count = r_err;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench: NAND sequencer with good/stuck gate models,
// start/abort/reset corner cases, and a NOR instance with short settle.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       resp;
  logic [1:0] stim;
  logic       busy, done, pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  logic       start_b = 1'b0;
  logic       abort_b = 1'b0;
  logic       resp_b;
  logic [1:0] stim_b;
  logic       busy_b, done_b, pass_b;
  logic [3:0] fail_b;
  logic [2:0] err_b;

  int mode = 0;
  int errors = 0;
  int checks = 0;
  int n_done, lat, bad;
  logic [7:0] snap;

  always #5 clk = ~clk;

  // mode 0: good NAND, 1: output stuck at 1, 2: output stuck at 0
  always_comb resp = (mode == 0) ? ~&stim : (mode == 1);
  always_comb resp_b = ~|stim_b;

  gate_bist_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .stim      (stim),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_vec  (fail_vec),
    .err_count (err_count)
  );

  gate_bist_ctrl #(
    .N_INPUTS      (2),
    .SETTLE_CYCLES (1),
    .TRUTH         (TRUTH_NOR2)
  ) u_nor (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .abort     (abort_b),
    .stim      (stim_b),
    .resp      (resp_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .fail_vec  (fail_b),
    .err_count (err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start at edge k; j counts cycles after edge k. stop = first idle cycle.
  task automatic run_a(input int abort_at, input int rst_at,
                       input bit poke, input int stop);
    n_done = 0;
    lat    = -1;
    bad    = 0;
    snap   = '1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      start = poke && (j == 4 || j == 12);
      abort = (j == abort_at);
      rst   = (j == rst_at);
      if (busy !== (j < stop) ||
          stim !== ((j < stop) ? 2'(j / 3) : 2'd0))
        bad++;
      if (done === 1'b1) begin
        n_done++;
        if (lat < 0) lat = j;
      end
      if (j == stop) snap = {pass, fail_vec, err_count};
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_vec", fail_vec, 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;

    mode = 0;
    run_a(-1, -1, 1'b0, 12);
    chk("good_stim_seq", bad, 0);
    chk("good_done_cnt", n_done, 1);
    chk("good_done_lat", lat, 12);
    chk("good_pass", pass, 1);
    chk("good_fail_vec", fail_vec, 4'b0000);
    chk("good_err", err_count, 0);

    mode = 1;
    run_a(-1, -1, 1'b0, 12);
    chk("s1_done_cnt", n_done, 1);
    chk("s1_fail_vec", fail_vec, 4'b1000);
    chk("s1_err", err_count, 1);
    chk("s1_pass", pass, 0);

    mode = 2;
    run_a(-1, -1, 1'b0, 12);
    chk("s0_fail_vec", fail_vec, 4'b0111);
    chk("s0_err", err_count, 3);
    chk("s0_pass", pass, 0);

    mode = 0;
    run_a(-1, -1, 1'b1, 12);
    chk("poke_stim_seq", bad, 0);
    chk("poke_done_cnt", n_done, 1);
    chk("poke_done_lat", lat, 12);
    chk("poke_pass", pass, 1);

    // start+abort together in IDLE: stay idle, results held
    mode = 1;
    run_a(-1, -1, 1'b0, 12);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_fail_vec_held", fail_vec, 4'b1000);
    @(negedge clk);
    chk("sa_still_idle", busy, 0);

    mode = 0;
    run_a(6, -1, 1'b0, 7);
    chk("abort_stim_seq", bad, 0);
    chk("abort_done_cnt", n_done, 0);
    chk("abort_results_next", snap, 8'h00);
    chk("abort_fail_vec", fail_vec, 0);
    chk("abort_err", err_count, 0);
    chk("abort_pass", pass, 0);

    mode = 0;
    run_a(-1, -1, 1'b0, 12);
    mode = 2;
    run_a(-1, 2, 1'b0, 3);
    chk("rstmid_stim_seq", bad, 0);
    chk("rstmid_done_cnt", n_done, 0);
    chk("rstmid_results", snap, 8'h00);
    mode = 0;
    run_a(-1, -1, 1'b0, 12);
    chk("rstmid_rerun_lat", lat, 12);
    chk("rstmid_rerun_pass", pass, 1);

    bad    = 0;
    n_done = 0;
    lat    = -1;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (busy_b !== (j < 8) ||
          stim_b !== ((j < 8) ? 2'(j / 2) : 2'd0))
        bad++;
      if (done_b === 1'b1) begin
        n_done++;
        if (lat < 0) lat = j;
      end
    end
    chk("nor_stim_seq", bad, 0);
    chk("nor_done_cnt", n_done, 1);
    chk("nor_done_lat", lat, 8);
    chk("nor_pass", pass_b, 1);
    chk("nor_fail_vec", fail_b, 0);
    chk("nor_err", err_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
